bft_leaf_tx: RTL
================

BFT_LEAF_TX -- requirements
Module: bft_leaf_tx

Interface
REQ-001 Parameter num_leaves, default 2: number of leaves in the tree.
REQ-002 Parameter payload_sz, default 1: payload width in bits.
REQ-003 Parameter addr, default 0: this leaf's own address.
REQ-004 Parameter fifo_depth, default 4: injection FIFO entries; power of two, at least 2.
REQ-005 Parameter min_gap, default 0: minimum idle cycles between consecutive injected packets; range 0..15.
REQ-006 Parameter p_sz, default 1+$clog2(num_leaves)+payload_sz: packet width.
REQ-007 clk  input  1  single clock; all logic on rising edge.
REQ-008 reset  input  1  synchronous, active-low reset (0 = reset).
REQ-009 din_valid  input  1  user beat offered.
REQ-010 din_ready  output  1  beat accepted when din_valid and din_ready are high on the same edge.
REQ-011 din_dest  input  $clog2(num_leaves)  destination leaf address.
REQ-012 din_payload  input  payload_sz  user payload.
REQ-013 stall_i  input  1  tree link cannot take a packet this cycle.
REQ-014 bus_o  output  p_sz  packet to tree: [p_sz-1] valid, [p_sz-2:payload_sz] dest, [payload_sz-1:0] payload.
REQ-015 drop_cnt  output  8  count of self-addressed beats dropped; saturating.

Function
REQ-016 din_ready SHALL be high exactly when the FIFO holds fewer than fifo_depth entries; combinational from FIFO occupancy only, never from din_valid.
REQ-017 An accepted beat with din_dest != addr SHALL be written to the FIFO.
REQ-018 An accepted beat with din_dest == addr SHALL be discarded, not written, and increment drop_cnt; drop_cnt SHALL hold at 255.
REQ-019 The block SHALL inject (launch) when the FIFO is non-empty, stall_i is low, and the gap counter is zero; the head entry is popped on that edge.
REQ-020 bus_o SHALL be registered; a launch on edge N drives bus_o with valid=1, the head's dest and payload, from edge N through the next edge.
REQ-021 In every cycle without a launch, bus_o SHALL be all zeros (VOID).
REQ-022 Latency: a beat accepted into an empty FIFO on edge N, with stall_i low and gap zero, SHALL appear on bus_o after edge N+1.
REQ-023 Gap counter SHALL load min_gap on each launch and decrement by one per cycle to zero; with min_gap=0, back-to-back launches are allowed every cycle.
REQ-024 Decrement SHALL continue while stall_i is high.
REQ-025 stall_i high SHALL suppress the launch; the head entry is retained unchanged; no packet is lost or duplicated.
REQ-026 Simultaneous push and pop on a full FIFO SHALL NOT occur: din_ready is low when full, so a pop frees a slot only for the next cycle.
REQ-027 Simultaneous push and pop on a non-full FIFO SHALL leave occupancy unchanged.
REQ-028 FIFO read/write pointers SHALL wrap modulo fifo_depth; occupancy SHALL be tracked with one extra bit to distinguish full from empty.
REQ-029 Packets SHALL be launched in acceptance order.

Reset
REQ-030 While reset is low at a rising edge: FIFO empty, pointers 0, gap counter 0, drop_cnt 0, bus_o 0.
REQ-031 din_ready SHALL be low during reset cycles and high from the first cycle after reset releases.
REQ-032 Reset asserted mid-operation SHALL discard all queued entries; no packet launches on the edge that samples reset low.

Structure
REQ-033 Valid/VOID bit position and packet field offsets SHALL come from the shared direction/packet constants header used by the switches.
REQ-034 The FIFO SHALL be a sub-module named sync_fifo (parameters width, depth; ports clk, reset, wr_en, din, rd_en, dout, full, empty).
REQ-035 Launch control, gap counter and drop counter SHALL be in bft_leaf_tx.

Verification
REQ-036 num_leaves=4, payload_sz=8, addr=0; push dest=2 payload=0xA5 with stall_i low -> bus_o=1_10_10100101 one cycle after acceptance, then zeros.
REQ-037 fifo_depth=4; stall_i held high; push 5 beats -> 4 accepted, din_ready low on 5th; release stall_i -> 4 packets launched in order on consecutive cycles.
REQ-038 min_gap=2; push 3 beats back-to-back -> launches separated by exactly 2 VOID cycles.
REQ-039 Push dest=addr 300 times -> no launches; drop_cnt=255.
REQ-040 Fill FIFO with 3 entries, assert reset for 1 cycle -> bus_o=0 thereafter, no stale packets, drop_cnt=0, din_ready high next cycle.
REQ-041 Toggle stall_i randomly with continuous pushes for 1000 cycles -> scoreboard: every non-self beat launched exactly once, in order, never while stall_i high.

Source files
------------

// File: rtl/bft_leaf_tx_pkg.sv
// ---------------------------------------------------------------------------
// bft_leaf_tx_pkg
// Shared packet and direction constants for the butterfly-fat-tree leaf and
// switch blocks. Every block that builds or parses a tree packet takes the
// valid/VOID bit value and the field offsets from here, so the packet layout
// only has to change in one place.
//
// Packet layout (p_sz bits):
//   [p_sz-1]              valid bit (PKT_VALID) or VOID (PKT_VOID)
//   [p_sz-2:payload_sz]   destination leaf address
//   [payload_sz-1:0]      payload
// ---------------------------------------------------------------------------
package bft_leaf_tx_pkg;

  // Port directions used by the switches when routing a packet.
  typedef enum logic [1:0] {
    DIR_LEFT  = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_UP    = 2'd2,
    DIR_NONE  = 2'd3
  } dir_e;

  // Value of the top bit for a real packet versus an idle link.
  localparam logic PKT_VALID = 1'b1;
  localparam logic PKT_VOID  = 1'b0;

  // Width of the inter-packet gap counter; it covers gaps of 0..15 cycles.
  localparam int GAP_W = 4;

  // Bit position of the valid flag inside a packet of width pSz.
  function automatic int validPos(input int pSz);
    return pSz - 1;
  endfunction

  // Lowest bit of the destination field; the payload sits directly below it.
  function automatic int destLsb(input int payloadSz);
    return payloadSz;
  endfunction

endpackage

// File: rtl/bft_leaf_tx_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with a show-ahead output: dout always presents the head
// entry, and rd_en pops it on the rising edge.
//
// Ports:
//   clk    - clock, all state changes on the rising edge
//   reset  - synchronous active-low reset, empties the FIFO
//   wr_en  - write din on this edge (ignored when full)
//   din    - entry to write
//   rd_en  - pop the head entry on this edge (ignored when empty)
//   dout   - current head entry (meaningless while empty)
//   full   - depth entries held
//   empty  - no entries held
// ---------------------------------------------------------------------------
module sync_fifo
  import bft_leaf_tx_pkg::*;
#(
  parameter int width = 8,
  parameter int depth = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [width-1:0] din,
  input  logic             rd_en,
  output logic [width-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(depth);

  // Pointers carry one bit beyond the address: equal pointers mean empty,
  // pointers differing only in that top bit mean full.
  logic [AW:0]      wrPtr_q, wrPtr_d;
  logic [AW:0]      rdPtr_q, rdPtr_d;
  logic [width-1:0] mem_q [depth];
  logic             doWrite;
  logic             doRead;

  // Occupancy flags and the guarded write/read strobes.
  always_comb begin
    empty   = (wrPtr_q == rdPtr_q);
    full    = (wrPtr_q[AW] != rdPtr_q[AW]) && (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
    doWrite = wr_en && !full;
    doRead  = rd_en && !empty;
    dout    = mem_q[rdPtr_q[AW-1:0]];
  end

  // Pointer advance; the power-of-two depth makes wrap-around free.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    if (doWrite) wrPtr_d = wrPtr_q + 1'b1;
    if (doRead)  rdPtr_d = rdPtr_q + 1'b1;
  end

  // Pointer registers; reset discards everything queued.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
    end
  end

  // Storage needs no reset: empty pointers hide any stale contents.
  always_ff @(posedge clk) begin
    if (doWrite) mem_q[wrPtr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/bft_leaf_tx.sv
// ---------------------------------------------------------------------------
// bft_leaf_tx
// Injection side of a butterfly-fat-tree leaf. User beats are queued in a
// small FIFO and launched into the tree one packet per cycle at most,
// honouring link back-pressure (stall_i) and a minimum idle gap between
// packets. Beats addressed to this leaf itself are dropped and counted.
//
// Ports:
//   clk         - clock, rising edge
//   reset       - synchronous active-low reset
//   din_valid   - user beat offered
//   din_ready   - FIFO has room (low while reset is asserted)
//   din_dest    - destination leaf address of the beat
//   din_payload - beat payload
//   stall_i     - tree link cannot take a packet this cycle
//   bus_o       - registered packet to the tree, all zeros when idle
//   drop_cnt    - saturating count of self-addressed beats dropped
// ---------------------------------------------------------------------------
module bft_leaf_tx
  import bft_leaf_tx_pkg::*;
#(
  parameter int num_leaves = 2,
  parameter int payload_sz = 1,
  parameter int addr       = 0,
  parameter int fifo_depth = 4,
  parameter int min_gap    = 0,
  parameter int p_sz       = 1 + $clog2(num_leaves) + payload_sz
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          din_valid,
  output logic                          din_ready,
  input  logic [$clog2(num_leaves)-1:0] din_dest,
  input  logic [payload_sz-1:0]         din_payload,
  input  logic                          stall_i,
  output logic [p_sz-1:0]               bus_o,
  output logic [7:0]                    drop_cnt
);

  localparam int                DEST_W    = $clog2(num_leaves);
  localparam int                ENTRY_W   = DEST_W + payload_sz;
  localparam int                VALID_POS = validPos(p_sz);
  localparam int                DEST_LSB  = destLsb(payload_sz);
  localparam logic [DEST_W-1:0] OWN_ADDR  = DEST_W'(addr);
  localparam logic [GAP_W-1:0]  GAP_LOAD  = GAP_W'(min_gap);

  logic               fifoFull;
  logic               fifoEmpty;
  logic [ENTRY_W-1:0] fifoDout;
  logic               accept;
  logic               selfBeat;
  logic               push;
  logic               launch;
  logic [GAP_W-1:0]   gapCnt_q, gapCnt_d;
  logic [7:0]         dropCnt_q, dropCnt_d;
  logic [p_sz-1:0]    bus_q, bus_d;

  sync_fifo #(
    .width (ENTRY_W),
    .depth (fifo_depth)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .wr_en (push),
    .din   ({din_dest, din_payload}),
    .rd_en (launch),
    .dout  (fifoDout),
    .full  (fifoFull),
    .empty (fifoEmpty)
  );

  // Handshake and launch decision. Ready depends only on occupancy (and is
  // forced low while reset is held); a launch is also blocked on the edge
  // that samples reset low so nothing escapes a mid-operation reset.
  always_comb begin
    din_ready = reset && !fifoFull;
    accept    = din_valid && din_ready;
    selfBeat  = (din_dest == OWN_ADDR);
    push      = accept && !selfBeat;
    launch    = reset && !fifoEmpty && !stall_i && (gapCnt_q == '0);
  end

  // Next state for the gap counter, drop counter and packet register.
  // The gap counter keeps running down while the link is stalled.
  always_comb begin
    gapCnt_d  = gapCnt_q;
    dropCnt_d = dropCnt_q;
    bus_d     = '0;
    if (launch) begin
      gapCnt_d = GAP_LOAD;
    end else if (gapCnt_q != '0) begin
      gapCnt_d = gapCnt_q - 1'b1;
    end
    if (accept && selfBeat && (dropCnt_q != 8'hFF)) begin
      dropCnt_d = dropCnt_q + 8'd1;
    end
    if (launch) begin
      bus_d[VALID_POS]            = PKT_VALID;
      bus_d[VALID_POS-1:DEST_LSB] = fifoDout[ENTRY_W-1:payload_sz];
      bus_d[DEST_LSB-1:0]         = fifoDout[payload_sz-1:0];
    end
  end

  // State registers; reset returns the link to VOID and clears counters.
  always_ff @(posedge clk) begin
    if (!reset) begin
      gapCnt_q  <= '0;
      dropCnt_q <= '0;
      bus_q     <= {p_sz{PKT_VOID}};
    end else begin
      gapCnt_q  <= gapCnt_d;
      dropCnt_q <= dropCnt_d;
      bus_q     <= bus_d;
    end
  end

  assign bus_o    = bus_q;
  assign drop_cnt = dropCnt_q;

endmodule
